// File: rtl/router_pkg.sv
// Shared types and constants for the Toeplitz buffer router and its sequencer.
package router_pkg;

  localparam int KERNEL_WIDTH = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_START   = 3'd2,
    S_COMPUTE = 3'd3,
    S_NEXT    = 3'd4,
    S_DONE    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/stream_buffer_writer.sv
// Streams ifmap pixels into the router register file, row-major, one write per
// valid/ready handshake; flags the handshake that completes the image.
module stream_buffer_writer
  import router_pkg::*;
#(
  parameter int dataSize = 8,
  parameter int nAddress = 8
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                active,
  input  logic                clr,
  input  logic [15:0]         area,
  input  logic [dataSize-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [dataSize-1:0] buf_wr_data,
  output logic [nAddress-1:0] buf_wr_addr,
  output logic                buf_wr_en,
  output logic                load_done
);

  logic [nAddress-1:0] load_cnt_q;
  logic [nAddress-1:0] load_cnt_d;

  // Write port, handshake and next pixel address.
  always_comb begin
    in_ready    = active;
    buf_wr_en   = in_valid & active;
    buf_wr_data = active ? in_data : {dataSize{1'b0}};
    buf_wr_addr = active ? load_cnt_q : {nAddress{1'b0}};
    load_done   = buf_wr_en && (16'(load_cnt_q) == (area - 16'd1));
    if (clr) begin
      load_cnt_d = {nAddress{1'b0}};
    end else if (load_done) begin
      load_cnt_d = {nAddress{1'b0}};
    end else if (buf_wr_en) begin
      load_cnt_d = load_cnt_q + nAddress'(1);
    end else begin
      load_cnt_d = load_cnt_q;
    end
  end

  // Pixel address register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      load_cnt_q <= {nAddress{1'b0}};
    end else begin
      load_cnt_q <= load_cnt_d;
    end
  end

endmodule

// File: rtl/router_sequencer.sv
// Per-channel sequencer for the Toeplitz buffer router: load ifmap, start the
// router, follow the window sweep until done, then advance to the next channel.
module router_sequencer
  import router_pkg::*;
#(
  parameter int dataSize    = 8,
  parameter int numRegister = 256,
  parameter int kernelWidth = KERNEL_WIDTH
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic [15:0]                      cfg_ifmap_width,
  input  logic [7:0]                       cfg_num_channels,
  input  logic                             ctrl_start,
  input  logic [dataSize-1:0]              in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [dataSize-1:0]              buf_wr_data,
  output logic [$clog2(numRegister)-1:0]   buf_wr_addr,
  output logic                             buf_wr_en,
  output logic                             buf_start,
  input  logic                             buf_done,
  output logic                             ofmap_valid,
  output logic [7:0]                       ch_idx,
  output logic                             busy,
  output logic                             flag_done,
  output logic                             err_cfg,
  output logic                             err_timeout
);

  localparam int nAddress = $clog2(numRegister);

  seq_state_t  state_q, state_d;
  logic [15:0] width_q, width_d;
  logic [7:0]  nch_q, nch_d;
  logic [7:0]  ch_idx_q, ch_idx_d;
  logic [15:0] cyc_cnt_q, cyc_cnt_d;
  logic        busy_q, busy_d;
  logic        flag_done_q, flag_done_d;
  logic        err_cfg_q, err_cfg_d;
  logic        err_timeout_q, err_timeout_d;

  logic [15:0] area;
  logic [15:0] out_edge;
  logic [15:0] win;
  logic [31:0] cfg_area;
  logic        cfg_ok;
  logic        wr_clr;
  logic        load_done;

  assign area     = width_q * width_q;
  assign out_edge = width_q - 16'(kernelWidth) + 16'd1;
  assign win      = out_edge * out_edge;
  // Legality uses a 32-bit area so a huge W cannot wrap into a small one.
  assign cfg_area = {16'd0, cfg_ifmap_width} * {16'd0, cfg_ifmap_width};
  assign cfg_ok   = (cfg_ifmap_width >= 16'(kernelWidth)) &&
                    (cfg_area <= 32'(numRegister)) &&
                    (cfg_num_channels != 8'd0);

  stream_buffer_writer #(
    .dataSize (dataSize),
    .nAddress (nAddress)
  ) u_writer (
    .clk         (clk),
    .nrst        (nrst),
    .active      (state_q == S_LOAD),
    .clr         (wr_clr),
    .area        (area),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .buf_wr_data (buf_wr_data),
    .buf_wr_addr (buf_wr_addr),
    .buf_wr_en   (buf_wr_en),
    .load_done   (load_done)
  );

  // Next-state, counters and combinational router controls.
  always_comb begin
    state_d       = state_q;
    width_d       = width_q;
    nch_d         = nch_q;
    ch_idx_d      = ch_idx_q;
    cyc_cnt_d     = cyc_cnt_q;
    err_cfg_d     = 1'b0;
    err_timeout_d = 1'b0;
    wr_clr        = 1'b0;
    buf_start     = 1'b0;
    ofmap_valid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctrl_start && cfg_ok) begin
          width_d  = cfg_ifmap_width;
          nch_d    = cfg_num_channels;
          ch_idx_d = 8'd0;
          wr_clr   = 1'b1;
          state_d  = S_LOAD;
        end else if (ctrl_start) begin
          err_cfg_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (load_done) begin
          state_d = S_START;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_START: begin
        buf_start   = 1'b1;
        ofmap_valid = 1'b1;
        cyc_cnt_d   = 16'd0;
        state_d     = S_COMPUTE;
      end
      S_COMPUTE: begin
        ofmap_valid = !buf_done;
        cyc_cnt_d   = cyc_cnt_q + 16'd1;
        if (buf_done) begin
          state_d = S_NEXT;
        end else if (cyc_cnt_q >= win) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          state_d = S_COMPUTE;
        end
      end
      S_NEXT: begin
        if (ch_idx_q == (nch_q - 8'd1)) begin
          state_d = S_DONE;
        end else begin
          ch_idx_d = ch_idx_q + 8'd1;
          wr_clr   = 1'b1;
          state_d  = S_LOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d      = (state_d != S_IDLE);
    flag_done_d = (state_d == S_DONE);
  end

  // State, latched configuration and registered status outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= S_IDLE;
      width_q       <= 16'd0;
      nch_q         <= 8'd0;
      ch_idx_q      <= 8'd0;
      cyc_cnt_q     <= 16'd0;
      busy_q        <= 1'b0;
      flag_done_q   <= 1'b0;
      err_cfg_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      width_q       <= width_d;
      nch_q         <= nch_d;
      ch_idx_q      <= ch_idx_d;
      cyc_cnt_q     <= cyc_cnt_d;
      busy_q        <= busy_d;
      flag_done_q   <= flag_done_d;
      err_cfg_q     <= err_cfg_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign ch_idx      = ch_idx_q;
  assign busy        = busy_q;
  assign flag_done   = flag_done_q;
  assign err_cfg     = err_cfg_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_router_sequencer.sv
// Self-checking bench: each scenario is expanded into an expected per-cycle
// timeline from the channel/pixel/window arithmetic, then replayed and compared.
module tb_router_sequencer;

  localparam int MAXT = 4000;

  logic        clk;
  logic        nrst;
  logic [15:0] cfg_ifmap_width;
  logic [7:0]  cfg_num_channels;
  logic        ctrl_start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  buf_wr_data;
  logic [7:0]  buf_wr_addr;
  logic        buf_wr_en;
  logic        buf_start;
  logic        buf_done;
  logic        ofmap_valid;
  logic [7:0]  ch_idx;
  logic        busy;
  logic        flag_done;
  logic        err_cfg;
  logic        err_timeout;

  router_sequencer dut (
    .clk              (clk),
    .nrst             (nrst),
    .cfg_ifmap_width  (cfg_ifmap_width),
    .cfg_num_channels (cfg_num_channels),
    .ctrl_start       (ctrl_start),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .buf_wr_data      (buf_wr_data),
    .buf_wr_addr      (buf_wr_addr),
    .buf_wr_en        (buf_wr_en),
    .buf_start        (buf_start),
    .buf_done         (buf_done),
    .ofmap_valid      (ofmap_valid),
    .ch_idx           (ch_idx),
    .busy             (busy),
    .flag_done        (flag_done),
    .err_cfg          (err_cfg),
    .err_timeout      (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus timeline
  int d_start[MAXT], d_valid[MAXT], d_data[MAXT], d_done[MAXT], d_nrst[MAXT];
  int d_w[MAXT], d_c[MAXT];
  // expected timeline
  int e_wr[MAXT], e_addr[MAXT], e_data[MAXT], e_start[MAXT], e_ofv[MAXT];
  int e_rdy[MAXT], e_ch[MAXT], e_busy[MAXT], e_flag[MAXT], e_ecfg[MAXT], e_eto[MAXT];

  int vectors = 0;
  int errors  = 0;
  int cur     = 0;
  bit chk_on  = 1'b0;
  int ch_hold = 0;
  int obs_wr = 0, obs_st = 0, obs_ofv = 0, obs_flag = 0, obs_ecfg = 0, obs_eto = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cur, act, exp);
    end
  endtask

  task automatic fill_ch();
    for (int i = 1; i < MAXT; i++) begin
      if (e_ch[i] < 0) e_ch[i] = e_ch[i-1];
    end
  endtask

  // Expand one scenario (start at cycle 2) into stimulus and expected outputs.
  task automatic build(input int w, input int c, input int vmode, input bit tmo,
                       input bit hold, input int rst_px, output int n);
    int s, t, k, ts, area, win;
    s = 2;
    for (int i = 0; i < MAXT; i++) begin
      d_start[i] = 0; d_nrst[i] = 1; d_done[i] = 0;
      d_valid[i] = (vmode == 0) ? 1 : (vmode == 1) ? (i % 2) : int'($urandom_range(0, 1));
      d_data[i]  = int'($urandom_range(0, 255));
      d_w[i]     = int'($urandom_range(0, 40));
      d_c[i]     = int'($urandom_range(0, 5));
      e_wr[i] = 0; e_addr[i] = 0; e_data[i] = 0; e_start[i] = 0; e_ofv[i] = 0;
      e_rdy[i] = 0; e_busy[i] = 0; e_flag[i] = 0; e_ecfg[i] = 0; e_eto[i] = 0;
      e_ch[i] = (i <= s) ? ch_hold : -1;
    end
    d_start[s] = 1; d_w[s] = w; d_c[s] = c;
    area = w * w;
    if (w < 3 || area > 256 || c == 0) begin
      e_ecfg[s+1] = 1;
      for (int i = s + 1; i < MAXT; i++) e_ch[i] = ch_hold;
      n = s + 5;
      return;
    end
    win = (w - 2) * (w - 2);
    t = s + 1;
    for (int chn = 0; chn < c; chn++) begin
      k = 0;
      while (k < area) begin
        if (t >= MAXT - 64) begin
          $display("FAIL build_overflow cycle=%0d got=%0d expected=%0d", t, t, MAXT - 64);
          $fatal(1);
        end
        if (rst_px >= 0 && k == rst_px) begin
          for (int i = t; i < MAXT; i++) e_ch[i] = 0;
          for (int i = t; i < t + 3; i++) d_nrst[i] = 0;
          ch_hold = 0;
          n = t + 6;
          return;
        end
        e_busy[t] = 1; e_rdy[t] = 1; e_ch[t] = chn;
        if (d_valid[t] != 0) begin
          if (vmode == 0) d_data[t] = k;
          e_wr[t] = 1; e_addr[t] = k; e_data[t] = d_data[t];
          k++;
        end
        t++;
      end
      ts = t;
      e_start[ts] = 1;
      if (tmo) begin
        // start cycle plus compute cycles with count 0..win all show a window
        for (int i = ts; i <= ts + win + 1; i++) begin e_ofv[i] = 1; e_busy[i] = 1; end
        e_eto[ts + win + 2] = 1;
        ch_hold = chn;
        n = ts + win + 6;
        fill_ch();
        return;
      end
      for (int i = ts; i <= ts + win - 2; i++) e_ofv[i] = 1;
      for (int i = ts; i <= ts + win; i++) e_busy[i] = 1;
      d_done[ts + win - 1] = 1;
      t = ts + win + 1;
    end
    e_busy[t] = 1; e_flag[t] = 1;
    if (hold) begin
      for (int i = s; i <= t; i++) d_start[i] = 1;
    end
    ch_hold = c - 1;
    n = t + 4;
    fill_ch();
  endtask

  task automatic play(input int n);
    for (int t = 0; t < n; t++) begin
      @(posedge clk); #1;
      nrst             = d_nrst[t][0];
      ctrl_start       = d_start[t][0];
      in_valid         = d_valid[t][0];
      in_data          = 8'(d_data[t]);
      buf_done         = d_done[t][0];
      cfg_ifmap_width  = 16'(d_w[t]);
      cfg_num_channels = 8'(d_c[t]);
      cur              = t;
      chk_on           = 1'b1;
    end
    @(posedge clk); #1;
    chk_on = 1'b0; nrst = 1'b1; ctrl_start = 1'b0; buf_done = 1'b0;
  endtask

  task automatic run(input string nm, input int w, input int c, input int vmode,
                     input bit tmo, input bit hold, input int rst_px,
                     input int x_wr, input int x_st, input int x_ofv,
                     input int x_flag, input int x_ecfg, input int x_eto);
    int n, b_wr, b_st, b_ofv, b_flag, b_ecfg, b_eto;
    build(w, c, vmode, tmo, hold, rst_px, n);
    b_wr = obs_wr; b_st = obs_st; b_ofv = obs_ofv;
    b_flag = obs_flag; b_ecfg = obs_ecfg; b_eto = obs_eto;
    play(n);
    check({nm, "_writes"},    obs_wr - b_wr,     x_wr);
    check({nm, "_starts"},    obs_st - b_st,     x_st);
    check({nm, "_ofv_cycles"}, obs_ofv - b_ofv,  x_ofv);
    check({nm, "_flag_done"}, obs_flag - b_flag, x_flag);
    check({nm, "_err_cfg"},   obs_ecfg - b_ecfg, x_ecfg);
    check({nm, "_err_to"},    obs_eto - b_eto,   x_eto);
  endtask

  // Per-cycle comparison against the expected timeline.
  always @(negedge clk) begin
    if (chk_on) begin
      check("in_ready",    in_ready,    e_rdy[cur]);
      check("buf_wr_en",   buf_wr_en,   e_wr[cur]);
      if (e_wr[cur] != 0 || d_nrst[cur] == 0) begin
        check("buf_wr_addr", buf_wr_addr, e_addr[cur]);
        check("buf_wr_data", buf_wr_data, e_data[cur]);
      end
      check("buf_start",   buf_start,   e_start[cur]);
      check("ofmap_valid", ofmap_valid, e_ofv[cur]);
      check("ch_idx",      ch_idx,      e_ch[cur]);
      check("busy",        busy,        e_busy[cur]);
      check("flag_done",   flag_done,   e_flag[cur]);
      check("err_cfg",     err_cfg,     e_ecfg[cur]);
      check("err_timeout", err_timeout, e_eto[cur]);
      obs_wr   += int'(buf_wr_en);
      obs_st   += int'(buf_start);
      obs_ofv  += int'(ofmap_valid);
      obs_flag += int'(flag_done);
      obs_ecfg += int'(err_cfg);
      obs_eto  += int'(err_timeout);
    end
  end

  initial begin
    int w, c;
    nrst = 1'b0; ctrl_start = 1'b1; in_valid = 1'b1; in_data = 8'hA5; buf_done = 1'b1;
    cfg_ifmap_width = 16'd4; cfg_num_channels = 8'd1;
    #23;
    check("rst_in_ready",    in_ready,    32'd0);
    check("rst_buf_wr_en",   buf_wr_en,   32'd0);
    check("rst_buf_wr_addr", buf_wr_addr, 32'd0);
    check("rst_buf_wr_data", buf_wr_data, 32'd0);
    check("rst_buf_start",   buf_start,   32'd0);
    check("rst_ofmap_valid", ofmap_valid, 32'd0);
    check("rst_ch_idx",      ch_idx,      32'd0);
    check("rst_busy",        busy,        32'd0);
    check("rst_flag_done",   flag_done,   32'd0);
    check("rst_err_cfg",     err_cfg,     32'd0);
    check("rst_err_timeout", err_timeout, 32'd0);
    ctrl_start = 1'b0; in_valid = 1'b0; buf_done = 1'b0;
    #10;
    nrst = 1'b1;

    run("w4c1",     4,  1, 0, 1'b0, 1'b0, -1, 16,  1, 3,   1, 0, 0);
    run("w5c2",     5,  2, 1, 1'b0, 1'b0, -1, 50,  2, 16,  1, 0, 0);
    run("w2_bad",   2,  1, 0, 1'b0, 1'b0, -1, 0,   0, 0,   0, 1, 0);
    run("w17_bad",  17, 1, 0, 1'b0, 1'b0, -1, 0,   0, 0,   0, 1, 0);
    run("c0_bad",   4,  0, 0, 1'b0, 1'b0, -1, 0,   0, 0,   0, 1, 0);
    run("hold",     4,  1, 0, 1'b0, 1'b1, -1, 16,  1, 3,   1, 0, 0);
    run("rst7",     4,  1, 0, 1'b0, 1'b0, 7,  7,   0, 0,   0, 0, 0);
    run("reload",   4,  1, 0, 1'b0, 1'b0, -1, 16,  1, 3,   1, 0, 0);
    run("timeout",  4,  1, 0, 1'b1, 1'b0, -1, 16,  1, 6,   0, 0, 1);
    run("w16",      16, 1, 1, 1'b0, 1'b0, -1, 256, 1, 195, 1, 0, 0);
    for (int r = 0; r < 4; r++) begin
      w = int'($urandom_range(4, 10));
      c = int'($urandom_range(1, 3));
      run("rand", w, c, 2, 1'b0, 1'b0, -1, w * w * c, c, c * ((w - 2) * (w - 2) - 1), 1, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/router_sequencer.md
Name: router_sequencer

Overview:
- Controller that sequences the Toeplitz buffer router for a multi-channel valid convolution.
- Per channel: accepts an ifmap stream over a valid/ready handshake and writes it row-major into the router register file. It then pulses the router start, tracks the output window sweep until router done, and advances to the next channel.
- Sits between the ifmap DMA/stream source and the router.
- Drives ofmap_valid/ch_idx for the downstream systolic array.

Parameters:
- dataSize, 8, pixel width in bits.
- numRegister, 256, router register-file depth.
- kernelWidth, 3, kernel edge; must match the router (nElementsOut = kernelWidth**2).
- nAddress (localparam), $clog2(numRegister), buffer address width.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- cfg_ifmap_width  in  16  ifmap edge W; sampled on accepted ctrl_start
- cfg_num_channels  in  8  channel count C; sampled on accepted ctrl_start
- ctrl_start  in  1  start request; honoured only in S_IDLE
- in_data  in  dataSize  ifmap pixel
- in_valid  in  1  in_data valid
- in_ready  out  1  sequencer accepts a pixel
- buf_wr_data  out  dataSize  router write data
- buf_wr_addr  out  nAddress  router write address
- buf_wr_en  out  1  router write enable
- buf_start  out  1  router start pulse
- buf_done  in  1  router done flag
- ofmap_valid  out  1  router rd_data holds a valid window this cycle
- ch_idx  out  8  current channel index
- busy  out  1  high in every state except S_IDLE
- flag_done  out  1  one-cycle pulse: all channels complete
- err_cfg  out  1  one-cycle pulse: start rejected
- err_timeout  out  1  one-cycle pulse: router never signalled done

Behaviour:
- Reset: state S_IDLE; load_cnt, cyc_cnt, ch_idx and latched config are 0; every output is 0.
- Derived values, computed from latched config at 16-bit width:
  - area = W*W
  - O = W - kernelWidth + 1
  - win = O*O
- States: S_IDLE, S_LOAD, S_START, S_COMPUTE, S_NEXT, S_DONE.
- S_IDLE:
  - Accepted ctrl_start with legal config latches W/C, clears ch_idx and load_cnt, and moves to S_LOAD.
  - Illegal config (W < kernelWidth, area > numRegister, or C == 0) pulses err_cfg in the following cycle and stays in S_IDLE.
- S_LOAD:
  - in_ready = 1.
  - buf_wr_en = in_valid & in_ready, combinational. buf_wr_data = in_data. buf_wr_addr = load_cnt.
  - The write therefore lands in the same cycle as the handshake.
  - load_cnt increments per handshake. The handshake at load_cnt == area-1 moves to S_START.
  - in_valid gaps stall with no writes.
- S_START:
  - buf_start = 1 for exactly one cycle; ofmap_valid = 1 (window 0,0); cyc_cnt cleared.
  - Next state S_COMPUTE.
- S_COMPUTE:
  - in_ready = 0; no buffer writes.
  - ofmap_valid = !buf_done; cyc_cnt increments.
  - buf_done = 1 moves to S_NEXT. The router raises done win-1 cycles after buf_start, so ofmap_valid is high for exactly win-1 cycles, counting S_START.
  - If cyc_cnt reaches win with no buf_done: pulse err_timeout, return to S_IDLE, clear busy.
- S_NEXT:
  - If ch_idx == C-1, go to S_DONE.
  - Otherwise increment ch_idx, clear load_cnt and go to S_LOAD. The previous buffer contents are overwritten in place.
- S_DONE: flag_done = 1 for one cycle, then S_IDLE.
- Outputs other than the combinational write port, in_ready, buf_start and ofmap_valid are registered.
- ctrl_start outside S_IDLE is ignored. Config changes while busy have no effect.
- in_valid outside S_LOAD is ignored, since in_ready = 0.
- Mid-operation reset: immediate return to reset values. buf_wr_en and buf_start are never asserted during or after reset until a new start.

Decomposition:
- Shared package router_pkg: the state typedef seq_state_t, plus a constant KERNEL_WIDTH used by both router and sequencer.
- One natural sub-module, stream_buffer_writer, owning the S_LOAD handshake, load_cnt and the write-port signals, with a load_done output.

Test Plan:
- W=4, C=1, continuous in_valid with data 0..15:
  - Expect 16 writes to addr 0..15 and a buf_start one cycle after the last write.
  - Expect ofmap_valid high for 3 cycles, then buf_done and a flag_done pulse.
  - Expect busy low after flag_done.
- W=5, C=2, in_valid toggling every other cycle:
  - Expect 25 writes per channel with no writes during gaps, ch_idx 0 then 1, and two buf_start pulses.
  - Expect ofmap_valid high for 8 cycles per channel and a single flag_done.
- Illegal starts:
  - W=2, C=1: err_cfg pulse, state stays S_IDLE, no writes.
  - W=17, C=1 (area 289 > 256): err_cfg pulse.
  - W=4, C=0: err_cfg pulse.
- ctrl_start and in_valid held high throughout a W=4 run: only the initial start is honoured; no writes during S_COMPUTE.
- nrst asserted after 7 pixels loaded:
  - All outputs go to 0 immediately; buf_wr_en stays low.
  - A subsequent start reloads from addr 0.
- Router model withholding buf_done with W=4: err_timeout pulse after cyc_cnt reaches 4, return to S_IDLE, no flag_done.
